// File: rtl/enc8b10b_pkg.sv
// Shared constants and helpers for the multi-lane 8b/10b encoder.
package enc8b10b_pkg;

    // Running disparity encodings.
    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    // Comma character as {k, HGFEDCBA}.
    localparam logic [8:0] K28_5 = 9'h1BC;

    // Control characters this encoder accepts: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
    localparam int NUM_LEGAL_K = 12;
    localparam logic [7:0] LEGAL_K [NUM_LEGAL_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_legal_k(input logic [7:0] data);
        logic legal;
        legal = 1'b0;
        for (int i = 0; i < NUM_LEGAL_K; i++) begin
            if (data == LEGAL_K[i]) legal = 1'b1;
        end
        return legal;
    endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// Combinational single-symbol 8b/10b encoder: 5b/6b + 3b/4b with running disparity.
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic       k_i,
    input  logic [7:0] data_i,
    input  logic       rd_i,
    output logic [9:0] sym_o,
    output logic       rd_o,
    output logic       kerr_o
);

    logic [8:0] char_w;
    logic [4:0] x_w;
    logic [2:0] y_w;
    logic [5:0] c6_neg_w, c6_w;
    logic [3:0] c4_neg_w, c4_w;
    logic       flip6_w, flip4_w, rd_mid_w, alt7_w;
    logic [9:0] abcdeifghj_w;

    // RD- column of the 5b/6b table, written in abcdei order (a is the MSB here).
    function automatic logic [5:0] table6(input logic [4:0] x);
        case (x)
            5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
            5'd10: return 6'b010101;  5'd11: return 6'b110100;
            5'd12: return 6'b001101;  5'd13: return 6'b101100;
            5'd14: return 6'b011100;  5'd15: return 6'b010111;
            5'd16: return 6'b011011;  5'd17: return 6'b100011;
            5'd18: return 6'b010011;  5'd19: return 6'b110010;
            5'd20: return 6'b001011;  5'd21: return 6'b101010;
            5'd22: return 6'b011010;  5'd23: return 6'b111010;
            5'd24: return 6'b110011;  5'd25: return 6'b100110;
            5'd26: return 6'b010110;  5'd27: return 6'b110110;
            5'd28: return 6'b001110;  5'd29: return 6'b101110;
            5'd30: return 6'b011110;  default: return 6'b101011;
        endcase
    endfunction

    // RD- column of the data 3b/4b table in fghj order (primary D.x.7).
    function automatic logic [3:0] table4d(input logic [2:0] y);
        case (y)
            3'd0: return 4'b1011;  3'd1: return 4'b1001;
            3'd2: return 4'b0101;  3'd3: return 4'b1100;
            3'd4: return 4'b1101;  3'd5: return 4'b1010;
            3'd6: return 4'b0110;  default: return 4'b1110;
        endcase
    endfunction

    // RD- column of the control 3b/4b table in fghj order.
    function automatic logic [3:0] table4k(input logic [2:0] y);
        case (y)
            3'd0: return 4'b1011;  3'd1: return 4'b0110;
            3'd2: return 4'b1010;  3'd3: return 4'b1100;
            3'd4: return 4'b1101;  3'd5: return 4'b0101;
            3'd6: return 4'b1001;  default: return 4'b0111;
        endcase
    endfunction

    // Substitute K28.5 for illegal controls, then encode both sub-blocks against the chained RD.
    always_comb begin
        kerr_o   = k_i && !is_legal_k(data_i);
        char_w   = kerr_o ? K28_5 : {k_i, data_i};
        x_w      = char_w[4:0];
        y_w      = char_w[7:5];

        // 6b block: at RD+ complement unbalanced codes, D.7 and every control code.
        c6_neg_w = (char_w[8] && x_w == 5'd28) ? 6'b001111 : table6(x_w);
        flip6_w  = char_w[8] || ($countones(c6_neg_w) != 3) || (c6_neg_w == 6'b111000);
        c6_w     = (rd_i == RD_POS && flip6_w) ? ~c6_neg_w : c6_neg_w;
        rd_mid_w = ($countones(c6_neg_w) == 3) ? rd_i : ~rd_i;

        // D.x.7 switches to the alternate form where the primary would make a run of five.
        alt7_w   = !char_w[8] && (y_w == 3'd7) &&
                   ((rd_mid_w == RD_NEG && (x_w == 5'd17 || x_w == 5'd18 || x_w == 5'd20)) ||
                    (rd_mid_w == RD_POS && (x_w == 5'd11 || x_w == 5'd13 || x_w == 5'd14)));
        if (char_w[8])   c4_neg_w = table4k(y_w);
        else if (alt7_w) c4_neg_w = 4'b0111;
        else             c4_neg_w = table4d(y_w);

        // 4b block: at RD+ complement unbalanced codes, D.x.3 and every control code.
        flip4_w  = char_w[8] || ($countones(c4_neg_w) != 2) || (c4_neg_w == 4'b1100);
        c4_w     = (rd_mid_w == RD_POS && flip4_w) ? ~c4_neg_w : c4_neg_w;
        rd_o     = ($countones(c4_neg_w) == 2) ? rd_mid_w : ~rd_mid_w;

        // Bus order is {j,h,g,f,i,e,d,c,b,a}: the bit reverse of abcdeifghj.
        abcdeifghj_w = {c6_w, c4_w};
        sym_o        = {<<{abcdeifghj_w}};
    end

endmodule

// File: rtl/enc8b10b_multilane.sv
// LANES-wide registered 8b/10b encoder with valid/ready handshake and comma idle fill.
module enc8b10b_multilane
    import enc8b10b_pkg::*;
#(
    parameter int LANES     = 4,
    parameter bit IDLE_FILL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*LANES-1:0]    in_data,
    input  logic [LANES-1:0]      in_k,
    input  logic                  disp_load,
    input  logic                  disp_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   out_data,
    output logic [LANES-1:0]      out_kerr,
    output logic                  rd_out
);

    logic                 valid_q, valid_d;
    logic [10*LANES-1:0]  data_q, data_d;
    logic [LANES-1:0]     kerr_q, kerr_d;
    logic                 rd_q, rd_d;

    logic                 rd_start_w;
    logic                 encode_w;
    logic [10*LANES-1:0]  enc_data_w;
    logic [LANES-1:0]     enc_kerr_w;
    logic                 enc_rd_w;

    assign in_ready   = !valid_q || out_ready;
    assign encode_w   = in_ready && (in_valid || IDLE_FILL);
    assign rd_start_w = disp_load ? disp_val : rd_q;

    // Lane encoders chained on RD: lane n starts from lane n-1's ending RD.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic rd_in_w, rd_end_w;
        if (n == 0) begin : g_first
            assign rd_in_w = rd_start_w;
        end else begin : g_chain
            assign rd_in_w = g_lane[n-1].rd_end_w;
        end
        enc8b10b_lane u_lane (
            .k_i    (in_valid ? in_k[n] : K28_5[8]),
            .data_i (in_valid ? in_data[8*n +: 8] : K28_5[7:0]),
            .rd_i   (rd_in_w),
            .sym_o  (enc_data_w[10*n +: 10]),
            .rd_o   (rd_end_w),
            .kerr_o (enc_kerr_w[n])
        );
    end
    assign enc_rd_w = g_lane[LANES-1].rd_end_w;

    // Next-state: take a word (or comma fill) when ready; a stalled output holds everything.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        kerr_d  = kerr_q;
        rd_d    = rd_q;
        if (encode_w) begin
            valid_d = 1'b1;
            data_d  = enc_data_w;
            kerr_d  = enc_kerr_w;
            rd_d    = enc_rd_w;
        end else if (in_ready) begin
            valid_d = 1'b0;
            rd_d    = rd_start_w;
        end
    end

    // Output and disparity registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            kerr_q  <= '0;
            rd_q    <= RD_NEG;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            kerr_q  <= kerr_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_kerr  = kerr_q;
    assign rd_out    = rd_q;

endmodule
